// File: rtl/ip4_tm_lkup.sv
// Tag lookup and refill control in front of the ip4_tm tag/state memory.
// Optional hit/miss statistics are built only when IP4_TM_STAT_EN is defined.
module ip4_tm_lkup #(
  parameter int GRP_W = 2,
  parameter int IDX_W = 6,
  parameter int TAG_W = 12,
  parameter int ST_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic [GRP_W-1:0] req_grp,
  input  logic [IDX_W-1:0] req_idx,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             req_wr,
  output logic [GRP_W-1:0] tm_grp0,
  output logic [IDX_W-1:0] tm_adr0,
  input  logic [TAG_W-1:0] tm_tag0,
  input  logic [ST_W-1:0]  tm_st0,
  output logic             tm_wrTag,
  output logic             tm_wrSt,
  output logic [GRP_W-1:0] tm_wgrp,
  output logic [IDX_W-1:0] tm_wadr,
  output logic [TAG_W-1:0] tm_wtag,
  output logic [ST_W-1:0]  tm_wst,
  output logic             rsp_vld,
  output logic             rsp_hit,
  output logic             fill_req,
  input  logic             fill_ack,
  output logic             fill_wb,
  output logic [TAG_W-1:0] fill_vtag,
  output logic [TAG_W-1:0] fill_tag,
  output logic [GRP_W-1:0] fill_grp,
  output logic [IDX_W-1:0] fill_idx,
  input  logic             stat_clr,
  output logic [31:0]      hit_cnt,
  output logic [31:0]      miss_cnt
);

  // state | meaning
  // IDLE  | ready; ip4_tm read address follows the request inputs
  // LOOK  | tag/state read data valid; hit/miss decided, outputs registered
  // CMP   | hit response or fill request visible on the outputs
  // FILL  | fill request held until fill_ack
  // UPD   | new tag/state written back, miss response visible
  typedef enum logic [2:0] {IDLE, LOOK, CMP, FILL, UPD} state_t;

  localparam logic [ST_W-1:0] ST_CLEAN = ST_W'(2'b01);
  localparam logic [ST_W-1:0] ST_DIRTY = ST_W'(2'b11);

  state_t state, state_nxt;

  logic [GRP_W-1:0] r_grp;
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_wr;

  logic             accept;
  logic             hit;
  logic             rsp_vld_nxt, rsp_hit_nxt;
  logic             wrtag_nxt, wrst_nxt;
  logic [TAG_W-1:0] wtag_nxt;
  logic [ST_W-1:0]  wst_nxt;
  logic             fill_req_nxt, fill_wb_nxt;
  logic [TAG_W-1:0] fill_vtag_nxt, fill_tag_nxt;
  logic [GRP_W-1:0] fill_grp_nxt;
  logic [IDX_W-1:0] fill_idx_nxt;

  assign req_rdy = (state == IDLE);
  assign tm_grp0 = (state == IDLE) ? req_grp : r_grp;
  assign tm_adr0 = (state == IDLE) ? req_idx : r_idx;
  assign tm_wgrp = r_grp;
  assign tm_wadr = r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    hit           = 1'b0;
    rsp_vld_nxt   = 1'b0;
    rsp_hit_nxt   = 1'b0;
    wrtag_nxt     = 1'b0;
    wrst_nxt      = 1'b0;
    wtag_nxt      = tm_wtag;
    wst_nxt       = tm_wst;
    fill_req_nxt  = fill_req;
    fill_wb_nxt   = fill_wb;
    fill_vtag_nxt = fill_vtag;
    fill_tag_nxt  = fill_tag;
    fill_grp_nxt  = fill_grp;
    fill_idx_nxt  = fill_idx;
    case (state)
      IDLE: begin
        if (req_vld) begin
          accept    = 1'b1;
          state_nxt = LOOK;
        end
      end
      LOOK: begin
        // Decided here so every CMP-cycle output comes straight from a flop.
        hit       = tm_st0[0] && (tm_tag0 == r_tag);
        state_nxt = CMP;
        if (hit) begin
          rsp_vld_nxt = 1'b1;
          rsp_hit_nxt = 1'b1;
          if (r_wr && !tm_st0[1]) begin
            wrst_nxt = 1'b1;
            wst_nxt  = ST_DIRTY;
          end
        end else begin
          fill_req_nxt  = 1'b1;
          fill_wb_nxt   = tm_st0[1] & tm_st0[0];
          fill_vtag_nxt = tm_tag0;
          fill_tag_nxt  = r_tag;
          fill_grp_nxt  = r_grp;
          fill_idx_nxt  = r_idx;
        end
      end
      CMP: begin
        state_nxt = fill_req ? FILL : IDLE;
      end
      FILL: begin
        if (fill_ack) begin
          fill_req_nxt  = 1'b0;
          fill_wb_nxt   = 1'b0;
          fill_vtag_nxt = '0;
          fill_tag_nxt  = '0;
          fill_grp_nxt  = '0;
          fill_idx_nxt  = '0;
          wrtag_nxt     = 1'b1;
          wrst_nxt      = 1'b1;
          wtag_nxt      = r_tag;
          wst_nxt       = r_wr ? ST_DIRTY : ST_CLEAN;
          rsp_vld_nxt   = 1'b1;
          state_nxt     = UPD;
        end
      end
      UPD: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grp     <= '0;
      r_idx     <= '0;
      r_tag     <= '0;
      r_wr      <= 1'b0;
      rsp_vld   <= 1'b0;
      rsp_hit   <= 1'b0;
      tm_wrTag  <= 1'b0;
      tm_wrSt   <= 1'b0;
      tm_wtag   <= '0;
      tm_wst    <= '0;
      fill_req  <= 1'b0;
      fill_wb   <= 1'b0;
      fill_vtag <= '0;
      fill_tag  <= '0;
      fill_grp  <= '0;
      fill_idx  <= '0;
    end else begin
      if (accept) begin
        r_grp <= req_grp;
        r_idx <= req_idx;
        r_tag <= req_tag;
        r_wr  <= req_wr;
      end
      rsp_vld   <= rsp_vld_nxt;
      rsp_hit   <= rsp_hit_nxt;
      tm_wrTag  <= wrtag_nxt;
      tm_wrSt   <= wrst_nxt;
      tm_wtag   <= wtag_nxt;
      tm_wst    <= wst_nxt;
      fill_req  <= fill_req_nxt;
      fill_wb   <= fill_wb_nxt;
      fill_vtag <= fill_vtag_nxt;
      fill_tag  <= fill_tag_nxt;
      fill_grp  <= fill_grp_nxt;
      fill_idx  <= fill_idx_nxt;
    end
  end

`ifdef IP4_TM_STAT_EN
  // Counted while the response is on the bus, so a clear in that cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (stat_clr) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rsp_vld) begin
      if (rsp_hit && (hit_cnt != 32'hFFFF_FFFF))
        hit_cnt <= hit_cnt + 32'd1;
      if (!rsp_hit && (miss_cnt != 32'hFFFF_FFFF))
        miss_cnt <= miss_cnt + 32'd1;
    end
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_ip4_tm_lkup.sv
// Bench for ip4_tm_lkup: behavioural ip4_tm model plus a response scoreboard.
module tb_ip4_tm_lkup;
  localparam int GRP_W = 2;
  localparam int IDX_W = 6;
  localparam int TAG_W = 12;
  localparam int ST_W  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_vld, req_rdy, req_wr;
  logic [GRP_W-1:0] req_grp;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [GRP_W-1:0] tm_grp0, tm_wgrp;
  logic [IDX_W-1:0] tm_adr0, tm_wadr;
  logic [TAG_W-1:0] tm_tag0, tm_wtag;
  logic [ST_W-1:0]  tm_st0, tm_wst;
  logic             tm_wrTag, tm_wrSt;
  logic             rsp_vld, rsp_hit;
  logic             fill_req, fill_ack, fill_wb;
  logic [TAG_W-1:0] fill_vtag, fill_tag;
  logic [GRP_W-1:0] fill_grp;
  logic [IDX_W-1:0] fill_idx;
  logic             stat_clr;
  logic [31:0]      hit_cnt, miss_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int seen_h = 0, seen_m = 0, base_h = 0, base_m = 0;
  logic sb[$];

  logic [TAG_W-1:0] mtag [4][64];
  logic [ST_W-1:0]  mst  [4][64];
  logic             pl_en = 1'b0;
  logic [GRP_W-1:0] pl_g;
  logic [IDX_W-1:0] pl_i;
  logic [TAG_W-1:0] pl_t;
  logic [ST_W-1:0]  pl_s;

  always #5 clk = ~clk;

  ip4_tm_lkup #(.GRP_W(GRP_W), .IDX_W(IDX_W), .TAG_W(TAG_W), .ST_W(ST_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_grp(req_grp), .req_idx(req_idx),
    .req_tag(req_tag), .req_wr(req_wr),
    .tm_grp0(tm_grp0), .tm_adr0(tm_adr0), .tm_tag0(tm_tag0), .tm_st0(tm_st0),
    .tm_wrTag(tm_wrTag), .tm_wrSt(tm_wrSt), .tm_wgrp(tm_wgrp), .tm_wadr(tm_wadr),
    .tm_wtag(tm_wtag), .tm_wst(tm_wst),
    .rsp_vld(rsp_vld), .rsp_hit(rsp_hit),
    .fill_req(fill_req), .fill_ack(fill_ack), .fill_wb(fill_wb), .fill_vtag(fill_vtag),
    .fill_tag(fill_tag), .fill_grp(fill_grp), .fill_idx(fill_idx),
    .stat_clr(stat_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // ip4_tm model: one-cycle read latency, writes on the clock edge.
  always @(posedge clk) begin
    tm_tag0 <= mtag[tm_grp0][tm_adr0];
    tm_st0  <= mst[tm_grp0][tm_adr0];
    if (pl_en) begin
      mtag[pl_g][pl_i] <= pl_t;
      mst[pl_g][pl_i]  <= pl_s;
    end
    if (tm_wrTag) mtag[tm_wgrp][tm_wadr] <= tm_wtag;
    if (tm_wrSt)  mst[tm_wgrp][tm_wadr]  <= tm_wst;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_vld) begin
      if (sb.size() == 0) chk("rsp_unexpected", {31'd0, rsp_vld}, 32'd0);
      else begin
        logic e;
        e = sb.pop_front();
        chk("rsp_hit_sb", {31'd0, rsp_hit}, {31'd0, e});
        if (e) seen_h++; else seen_m++;
      end
    end
  end

  task automatic load(input int g, input int i, input int t, input int s);
    pl_en = 1'b1;
    pl_g = GRP_W'(g); pl_i = IDX_W'(i); pl_t = TAG_W'(t); pl_s = ST_W'(s);
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic chk_cnt(input string tag);
`ifdef IP4_TM_STAT_EN
    chk({tag, "_hit_cnt"}, hit_cnt, 32'(seen_h - base_h));
    chk({tag, "_miss_cnt"}, miss_cnt, 32'(seen_m - base_m));
`else
    chk({tag, "_hit_cnt"}, hit_cnt, 32'd0);
    chk({tag, "_miss_cnt"}, miss_cnt, 32'd0);
`endif
  endtask

  task automatic do_req(input int g, input int i, input int t, input logic w,
                        input int ack_dly, input logic clr);
    logic [TAG_W-1:0] tg, vt;
    logic [ST_W-1:0]  s0;
    logic             e_hit, e_wb, e_wst;
    tg    = TAG_W'(t);
    vt    = mtag[g][i];
    s0    = mst[g][i];
    e_hit = s0[0] && (vt == tg);
    e_wb  = s0[1] & s0[0];
    e_wst = w && !s0[1];
    chk("req_rdy_t", {31'd0, req_rdy}, 32'd1);
    req_vld = 1'b1; req_grp = GRP_W'(g); req_idx = IDX_W'(i); req_tag = tg; req_wr = w;
    sb.push_back(e_hit);
    @(negedge clk);
    req_vld = 1'b0;
    chk("look_rdy", {31'd0, req_rdy}, 32'd0);
    chk("look_rsp", {31'd0, rsp_vld}, 32'd0);
    @(negedge clk);
    chk("rsp_t2", {31'd0, rsp_vld}, {31'd0, e_hit});
    chk("wrtag_t2", {31'd0, tm_wrTag}, 32'd0);
    if (e_hit) begin
      chk("wrst_hit", {31'd0, tm_wrSt}, {31'd0, e_wst});
      if (e_wst) chk("wst_hit", 32'(tm_wst), 32'h3);
      chk("fill_req_hit", {31'd0, fill_req}, 32'd0);
      if (clr) stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      if (clr) begin base_h = seen_h; base_m = seen_m; end
      chk("rdy_t3", {31'd0, req_rdy}, 32'd1);
      chk("rsp_t3", {31'd0, rsp_vld}, 32'd0);
      chk("mst_after_hit", 32'(mst[g][i]), e_wst ? 32'h3 : 32'(s0));
    end else begin
      chk("fill_req_t2", {31'd0, fill_req}, 32'd1);
      chk("fill_wb", {31'd0, fill_wb}, {31'd0, e_wb});
      chk("fill_vtag", 32'(fill_vtag), 32'(vt));
      chk("fill_tag", 32'(fill_tag), 32'(tg));
      chk("fill_grp", 32'(fill_grp), 32'(g));
      chk("fill_idx", 32'(fill_idx), 32'(i));
      chk("wrst_t2", {31'd0, tm_wrSt}, 32'd0);
      @(negedge clk);
      for (int k = 0; k < ack_dly; k++) begin
        chk("fill_hold_req", {31'd0, fill_req}, 32'd1);
        chk("fill_hold_vtag", {fill_wb, 19'd0, fill_vtag}, {e_wb, 19'd0, vt});
        chk("fill_hold_tag", {fill_grp, fill_idx, 12'd0, fill_tag}, {GRP_W'(g), IDX_W'(i), 12'd0, tg});
        chk("fill_hold_nowr", {30'd0, tm_wrTag, tm_wrSt}, 32'd0);
        @(negedge clk);
      end
      fill_ack = 1'b1;
      chk("fill_req_at_ack", {31'd0, fill_req}, 32'd1);
      @(negedge clk);
      fill_ack = 1'b0;
      chk("upd_wr", {30'd0, tm_wrTag, tm_wrSt}, 32'h3);
      chk("upd_wtag", 32'(tm_wtag), 32'(tg));
      chk("upd_wst", 32'(tm_wst), w ? 32'h3 : 32'h1);
      chk("upd_wadr", {tm_wgrp, tm_wadr}, {GRP_W'(g), IDX_W'(i)});
      chk("upd_rsp", {30'd0, rsp_vld, rsp_hit}, 32'h2);
      chk("upd_fill_req", {31'd0, fill_req}, 32'd0);
      @(negedge clk);
      chk("rdy_a2", {31'd0, req_rdy}, 32'd1);
      chk("nowr_a2", {30'd0, tm_wrTag, tm_wrSt}, 32'd0);
      chk("mtag_after_fill", 32'(mtag[g][i]), 32'(tg));
      chk("mst_after_fill", 32'(mst[g][i]), w ? 32'h3 : 32'h1);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_vld = 1'b0; req_grp = '0; req_idx = '0; req_tag = '0; req_wr = 1'b0;
    fill_ack = 1'b0; stat_clr = 1'b0;
    for (int g = 0; g < 4; g++)
      for (int i = 0; i < 64; i++) begin mtag[g][i] = '0; mst[g][i] = '0; end
    repeat (2) @(negedge clk);
    chk("rst_rdy", {31'd0, req_rdy}, 32'd1);
    chk("rst_outs", {rsp_vld, rsp_hit, tm_wrTag, tm_wrSt, fill_req, fill_wb}, 32'd0);
    chk("rst_fill_vtag", 32'(fill_vtag), 32'd0);
    chk_cnt("rst");
    rst_n = 1'b1;
    @(negedge clk);
    load(0, 5, 'h123, 1);
    load(0, 7, 'h0AA, 3);
    load(0, 9, 'h055, 0);
    load(1, 5, 'h123, 3);
    load(2, 3, 'h0F0, 1);
    @(negedge clk);

    do_req(0, 5, 'h123, 1'b0, 0, 1'b0);   // clean read hit
    do_req(0, 5, 'h123, 1'b1, 0, 1'b0);   // store hit marks dirty
    do_req(0, 5, 'h123, 1'b1, 0, 1'b0);   // store hit already dirty
    do_req(0, 7, 'h0BB, 1'b0, 10, 1'b0);  // dirty victim, slow ack
    do_req(0, 9, 'h055, 1'b1, 0, 1'b0);   // invalid line with equal tag, ack in first FILL cycle
    chk_cnt("after_5");
    do_req(0, 9, 'h055, 1'b0, 0, 1'b1);   // hit with coincident clear
    chk_cnt("after_clr");
    do_req(1, 5, 'h124, 1'b0, 2, 1'b0);   // dirty victim in another group
    do_req(0, 5, 'h123, 1'b0, 0, 1'b0);
    chk_cnt("after_grp");

    do_req(2, 3, 'h0F1, 1'b0, 0, 1'b0);   // warm miss before reset test
    sb.push_back(1'b0);
    req_vld = 1'b1; req_grp = 2'd2; req_idx = 6'd3; req_tag = 12'h0F2; req_wr = 1'b1;
    @(negedge clk);
    req_vld = 1'b0;
    @(negedge clk);
    chk("rst_pre_fill", {31'd0, fill_req}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_fill_drop", {31'd0, fill_req}, 32'd0);
    chk("rst_idle", {31'd0, req_rdy}, 32'd1);
    sb.delete();
    base_h = seen_h; base_m = seen_m;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      fill_ack = (k == 1);
      @(negedge clk);
      chk("post_rst_quiet", {29'd0, tm_wrTag, tm_wrSt, rsp_vld}, 32'd0);
    end
    fill_ack = 1'b0;
    chk("post_rst_mtag", 32'(mtag[2][3]), 32'h0F1);
    chk_cnt("post_rst");
    do_req(2, 3, 'h0F1, 1'b0, 0, 1'b0);   // recovery hit on the refilled line
    chk_cnt("final");
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
